// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
// Shared tile-fabric types plus the core-to-fabric request bridge types.
//   t_tile_id / t_tile_trans / opcodes / cardinals : fabric transaction format
//   t_c2f_state      : bridge FSM states
//   t_c2f_wr_entry   : posted-write buffer entry {address, data, byte enable}
//   C2F_TIMEOUT_DATA : data returned to the core when a remote read times out
// -----------------------------------------------------------------------------
package common_pkg;

    typedef logic [7:0] t_tile_id;

    typedef enum logic [1:0] {
        WR     = 2'd0,
        RD     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_tile_opcode;

    typedef enum logic [2:0] {
        NULL_CARDINAL = 3'd0,
        NORTH         = 3'd1,
        SOUTH         = 3'd2,
        EAST          = 3'd3,
        WEST          = 3'd4
    } t_cardinal;

    typedef struct packed {
        t_tile_opcode opcode;
        logic [31:0]  address;
        logic [31:0]  data;
        logic [3:0]   byte_en;
        t_tile_id     requestor_id;
        t_cardinal    next_tile_fifo_arb_id;
    } t_tile_trans;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        SEND_RD  = 3'd2,
        WAIT_RSP = 3'd3,
        RSP      = 3'd4
    } t_c2f_state;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  byte_en;
    } t_c2f_wr_entry;

    localparam logic [31:0] C2F_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // An address targets another tile when its top byte is neither the
    // local-memory window (0) nor this tile's own id.
    function automatic logic c2f_is_remote(input logic [31:0] addr, input t_tile_id own_id);
        return (addr[31:24] != 8'h00) && (addr[31:24] != own_id);
    endfunction

endpackage

// File: rtl/big_core_c2f_wr_fifo.sv
// -----------------------------------------------------------------------------
// big_core_c2f_wr_fifo
// Posted-write buffer for remote stores. DEPTH must be a power of two (>= 2)
// so the pointers wrap naturally.
//   clk, rst            : clock, async active-high reset
//   push_i, push_data_i : write an entry (ignored when full and not popping)
//   pop_i               : drop the head entry (ignored when empty)
//   head_o              : oldest entry
//   full_o, empty_o     : occupancy flags
// -----------------------------------------------------------------------------
module big_core_c2f_wr_fifo
    import common_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  t_c2f_wr_entry push_data_i,
    input  logic          pop_i,
    output t_c2f_wr_entry head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    t_c2f_wr_entry    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_s;
    logic             pop_s;

    assign empty_o = (count_q == CNT_W'(0));
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign pop_s   = pop_i && !empty_o;
    // A full buffer can still take a push in the cycle its head leaves.
    assign push_s  = push_i && (!full_o || pop_s);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/big_core_c2f_req.sv
// -----------------------------------------------------------------------------
// big_core_c2f_req
// Core-to-fabric request bridge. Remote stores are posted through a write
// buffer; a remote load stalls the core, drains older writes, issues one RD
// and waits for the RD_RSP before releasing the core.
// Optional feature macro: BIG_CORE_C2F_TIMEOUT_EN (read-response timeout that
// returns C2F_TIMEOUT_DATA and sets the sticky C2F_TimeoutErr).
//   Clk, Rst                      : clock, async active-high reset
//   local_tile_id                 : own tile id
//   DMemAddressQ103H/WrData/ByteEn/WrEn/RdEn : core request
//   C2F_StallQ103H                : core must hold request and freeze
//   C2F_RdRspValidQ104H/DataQ104H : remote load data return
//   OutFabricValid/Q/ReadyQ503H   : request toward the fabric
//   InFabricValidQ505H/Q505H      : response from the fabric
//   C2F_TimeoutErr                : sticky timeout flag
// -----------------------------------------------------------------------------
module big_core_c2f_req
    import common_pkg::*;
#(
    parameter int WR_FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  t_tile_id    local_tile_id,
    input  logic [31:0] DMemAddressQ103H,
    input  logic [31:0] DMemWrDataQ103H,
    input  logic [3:0]  DMemByteEnQ103H,
    input  logic        DMemWrEnQ103H,
    input  logic        DMemRdEnQ103H,
    output logic        C2F_StallQ103H,
    output logic        C2F_RdRspValidQ104H,
    output logic [31:0] C2F_RdRspDataQ104H,
    output logic        OutFabricValidQ503H,
    output t_tile_trans OutFabricQ503H,
    input  logic        OutFabricReadyQ503H,
    input  logic        InFabricValidQ505H,
    input  t_tile_trans InFabricQ505H,
    output logic        C2F_TimeoutErr
);

    t_c2f_state    state_q, state_d;
    logic [31:0]   rd_addr_q, rd_addr_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          remote_s, ld_req_s, st_req_s;
    logic          wr_phase_s, fifo_push_s, fifo_pop_s;
    logic          fifo_full_s, fifo_empty_s;
    logic          rsp_arrive_s, timeout_hit_s;
    t_c2f_wr_entry fifo_head_s, fifo_in_s;

    assign remote_s     = c2f_is_remote(DMemAddressQ103H, local_tile_id);
    assign ld_req_s     = DMemRdEnQ103H && remote_s;
    assign st_req_s     = DMemWrEnQ103H && !DMemRdEnQ103H && remote_s;
    assign fifo_in_s    = '{address: DMemAddressQ103H, data: DMemWrDataQ103H, byte_en: DMemByteEnQ103H};
    // Writes may only use the fabric port while no read is in flight.
    assign wr_phase_s   = (state_q == IDLE) || (state_q == DRAIN);
    assign fifo_pop_s   = wr_phase_s && !fifo_empty_s && OutFabricReadyQ503H;
    assign rsp_arrive_s = InFabricValidQ505H && (InFabricQ505H.opcode == RD_RSP);

    logic unused_in_fabric_s;
    assign unused_in_fabric_s = ^{InFabricQ505H.address, InFabricQ505H.byte_en,
                                  InFabricQ505H.requestor_id, InFabricQ505H.next_tile_fifo_arb_id};

    big_core_c2f_wr_fifo #(
        .DEPTH (WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .clk         (Clk),
        .rst         (Rst),
        .push_i      (fifo_push_s),
        .push_data_i (fifo_in_s),
        .pop_i       (fifo_pop_s),
        .head_o      (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // FSM next state, load address / response capture, push and stall.
    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        rsp_data_d     = rsp_data_q;
        fifo_push_s    = 1'b0;
        C2F_StallQ103H = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_req_s) begin
                    C2F_StallQ103H = 1'b1;
                    rd_addr_d      = DMemAddressQ103H;
                    state_d        = fifo_empty_s ? SEND_RD : DRAIN;
                end else if (st_req_s) begin
                    fifo_push_s    = !fifo_full_s || fifo_pop_s;
                    C2F_StallQ103H = !fifo_push_s;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                C2F_StallQ103H = 1'b1;
                if (fifo_empty_s) begin
                    state_d = SEND_RD;
                end else begin
                    state_d = DRAIN;
                end
            end
            SEND_RD: begin
                C2F_StallQ103H = 1'b1;
                if (OutFabricReadyQ503H) begin
                    state_d = WAIT_RSP;
                end else begin
                    state_d = SEND_RD;
                end
            end
            WAIT_RSP: begin
                C2F_StallQ103H = 1'b1;
                if (rsp_arrive_s) begin
                    rsp_data_d = InFabricQ505H.data;
                    state_d    = RSP;
                end else if (timeout_hit_s) begin
                    rsp_data_d = C2F_TIMEOUT_DATA;
                    state_d    = RSP;
                end else begin
                    state_d = WAIT_RSP;
                end
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fabric request mux: FIFO head while writing, the latched read in SEND_RD.
    always_comb begin
        OutFabricValidQ503H = 1'b0;
        OutFabricQ503H      = '0;
        if (state_q == SEND_RD) begin
            OutFabricValidQ503H                  = 1'b1;
            OutFabricQ503H.opcode                = RD;
            OutFabricQ503H.address               = rd_addr_q;
            OutFabricQ503H.data                  = 32'h0000_0000;
            OutFabricQ503H.byte_en               = 4'hF;
            OutFabricQ503H.requestor_id          = local_tile_id;
            OutFabricQ503H.next_tile_fifo_arb_id = NULL_CARDINAL;
        end else if (wr_phase_s && !fifo_empty_s) begin
            OutFabricValidQ503H                  = 1'b1;
            OutFabricQ503H.opcode                = WR;
            OutFabricQ503H.address               = fifo_head_s.address;
            OutFabricQ503H.data                  = fifo_head_s.data;
            OutFabricQ503H.byte_en               = fifo_head_s.byte_en;
            OutFabricQ503H.requestor_id          = local_tile_id;
            OutFabricQ503H.next_tile_fifo_arb_id = NULL_CARDINAL;
        end else begin
            OutFabricValidQ503H = 1'b0;
        end
    end

    assign C2F_RdRspValidQ104H = (state_q == RSP);
    assign C2F_RdRspDataQ104H  = (state_q == RSP) ? rsp_data_q : 32'h0000_0000;

    // FSM state and read-path registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            rd_addr_q  <= 32'h0000_0000;
            rsp_data_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef BIG_CORE_C2F_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc_s;
    logic            to_err_q, to_err_d;

    assign to_cnt_inc_s = to_cnt_q + TO_W'(1);

    // Counts WAIT_RSP cycles; fires on the cycle the count reaches the limit.
    always_comb begin
        to_cnt_d      = '0;
        to_err_d      = to_err_q;
        timeout_hit_s = 1'b0;
        if (state_q == WAIT_RSP) begin
            to_cnt_d      = to_cnt_inc_s;
            timeout_hit_s = (to_cnt_inc_s == TO_W'(TIMEOUT_CYCLES)) && !rsp_arrive_s;
        end else begin
            to_cnt_d = '0;
        end
        if (timeout_hit_s) begin
            to_err_d = 1'b1;
        end else begin
            to_err_d = to_err_q;
        end
    end

    // Timeout counter and sticky error flag, cleared only by reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign C2F_TimeoutErr = to_err_q;
`else
    localparam int unused_timeout_cycles_p = TIMEOUT_CYCLES;

    assign timeout_hit_s  = 1'b0;
    assign C2F_TimeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_big_core_c2f_req.sv
module tb_big_core_c2f_req;
    import common_pkg::*;

    localparam t_tile_id LOCAL_ID = 8'h05;

    logic        Clk = 1'b0;
    logic        Rst;
    t_tile_id    local_tile_id;
    logic [31:0] DMemAddressQ103H, DMemWrDataQ103H;
    logic [3:0]  DMemByteEnQ103H;
    logic        DMemWrEnQ103H, DMemRdEnQ103H;
    logic        C2F_StallQ103H, C2F_RdRspValidQ104H;
    logic [31:0] C2F_RdRspDataQ104H;
    logic        OutFabricValidQ503H, OutFabricReadyQ503H;
    t_tile_trans OutFabricQ503H;
    logic        InFabricValidQ505H;
    t_tile_trans InFabricQ505H;
    logic        C2F_TimeoutErr;

    big_core_c2f_req #(
        .WR_FIFO_DEPTH  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Clk                 (Clk),
        .Rst                 (Rst),
        .local_tile_id       (local_tile_id),
        .DMemAddressQ103H    (DMemAddressQ103H),
        .DMemWrDataQ103H     (DMemWrDataQ103H),
        .DMemByteEnQ103H     (DMemByteEnQ103H),
        .DMemWrEnQ103H       (DMemWrEnQ103H),
        .DMemRdEnQ103H       (DMemRdEnQ103H),
        .C2F_StallQ103H      (C2F_StallQ103H),
        .C2F_RdRspValidQ104H (C2F_RdRspValidQ104H),
        .C2F_RdRspDataQ104H  (C2F_RdRspDataQ104H),
        .OutFabricValidQ503H (OutFabricValidQ503H),
        .OutFabricQ503H      (OutFabricQ503H),
        .OutFabricReadyQ503H (OutFabricReadyQ503H),
        .InFabricValidQ505H  (InFabricValidQ505H),
        .InFabricQ505H       (InFabricQ505H),
        .C2F_TimeoutErr      (C2F_TimeoutErr)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    t_tile_trans exp_fab_q[$];
    logic [31:0] exp_rsp_q[$];
    t_tile_trans mon_fab_e;
    logic [31:0] mon_rsp_e;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        wr;
        logic        rd;
        logic        hit;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic t_tile_trans mk(input t_tile_opcode op, input logic [31:0] a,
                                       input logic [31:0] d, input logic [3:0] be);
        t_tile_trans t;
        t.opcode                = op;
        t.address               = a;
        t.data                  = d;
        t.byte_en               = be;
        t.requestor_id          = LOCAL_ID;
        t.next_tile_fifo_arb_id = NULL_CARDINAL;
        return t;
    endfunction

    function automatic t_tile_trans mk_rsp(input logic [31:0] d);
        t_tile_trans t;
        t                       = '0;
        t.opcode                = RD_RSP;
        t.data                  = d;
        t.requestor_id          = 8'h03;
        return t;
    endfunction

    // Scoreboard: compare every accepted fabric request and every read return.
    always @(negedge Clk) begin
        if (!Rst && OutFabricValidQ503H && OutFabricReadyQ503H) begin
            if (exp_fab_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fabric_unexpected: got %0h expected none", OutFabricQ503H);
            end else begin
                mon_fab_e = exp_fab_q.pop_front();
                check("fabric_trans", OutFabricQ503H, mon_fab_e);
            end
        end
        if (!Rst && C2F_RdRspValidQ104H) begin
            if (exp_rsp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %0h expected none", C2F_RdRspDataQ104H);
            end else begin
                mon_rsp_e = exp_rsp_q.pop_front();
                check("rsp_data", C2F_RdRspDataQ104H, mon_rsp_e);
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_in();
        DMemWrEnQ103H      = 1'b0;
        DMemRdEnQ103H      = 1'b0;
        InFabricValidQ505H = 1'b0;
        InFabricQ505H      = '0;
    endtask

    task automatic wait_fab_drained(input string name, input int max);
        int n;
        n = 0;
        while (exp_fab_q.size() != 0 && n < max) begin
            cyc();
            n++;
        end
        check(name, exp_fab_q.size() == 0, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic prev_hit;

        vecs[0] = '{32'h0200_0010, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h0500_0020, 32'h1111_1111, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0040, 32'h2222_2222, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'hFF00_0000, 32'h3333_3333, 4'hC, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_1000, 32'h0000_0000, 4'hF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h0500_0004, 32'h0000_0000, 4'hF, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h0100_0008, 32'h4444_4444, 4'h3, 1'b1, 1'b0, 1'b1};

        Rst                 = 1'b1;
        local_tile_id       = LOCAL_ID;
        DMemAddressQ103H    = 32'h0000_0000;
        DMemWrDataQ103H     = 32'h0000_0000;
        DMemByteEnQ103H     = 4'h0;
        OutFabricReadyQ503H = 1'b0;
        idle_in();
        #2;
        check("rst_stall", C2F_StallQ103H, 1'b0);
        check("rst_fab_valid", OutFabricValidQ503H, 1'b0);
        check("rst_fab_trans", OutFabricQ503H, 128'd0);
        check("rst_rsp_valid", C2F_RdRspValidQ104H, 1'b0);
        check("rst_rsp_data", C2F_RdRspDataQ104H, 32'h0000_0000);
        check("rst_timeout_err", C2F_TimeoutErr, 1'b0);
        cyc();
        cyc();
        Rst = 1'b0;

        // Table: single-cycle stores/loads with Ready high.
        OutFabricReadyQ503H = 1'b1;
        prev_hit = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            check("tbl_valid_next", OutFabricValidQ503H, prev_hit);
            DMemAddressQ103H = vecs[i].addr;
            DMemWrDataQ103H  = vecs[i].data;
            DMemByteEnQ103H  = vecs[i].be;
            DMemWrEnQ103H    = vecs[i].wr;
            DMemRdEnQ103H    = vecs[i].rd;
            #1;
            check("tbl_stall", C2F_StallQ103H, 1'b0);
            if (vecs[i].hit) begin
                exp_fab_q.push_back(mk(WR, vecs[i].addr, vecs[i].data, vecs[i].be));
            end
            prev_hit = vecs[i].hit;
        end
        cyc();
        idle_in();
        check("tbl_valid_last", OutFabricValidQ503H, prev_hit);
        wait_fab_drained("tbl_drain", 5);

        // Full buffer: fifth store stalls until a slot frees.
        cyc();
        OutFabricReadyQ503H = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            DMemWrEnQ103H    = 1'b1;
            DMemAddressQ103H = 32'h0200_0100 + 32'(i * 4);
            DMemWrDataQ103H  = 32'hA000_0000 + 32'(i);
            DMemByteEnQ103H  = 4'hF;
            #1;
            check("full_stall", C2F_StallQ103H, (i == 4));
            if (i < 4) exp_fab_q.push_back(mk(WR, DMemAddressQ103H, DMemWrDataQ103H, 4'hF));
        end
        cyc();
        check("full_stall_hold", C2F_StallQ103H, 1'b1);
        OutFabricReadyQ503H = 1'b1;
        #1;
        check("full_stall_release", C2F_StallQ103H, 1'b0);
        exp_fab_q.push_back(mk(WR, DMemAddressQ103H, DMemWrDataQ103H, 4'hF));
        cyc();
        idle_in();
        wait_fab_drained("full_drain", 10);
        cyc();
        check("full_empty", OutFabricValidQ503H, 1'b0);

        // Writes ordered ahead of a remote load; stray response before the read is dropped.
        OutFabricReadyQ503H = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) cyc();
            DMemWrEnQ103H    = 1'b1;
            DMemAddressQ103H = 32'h0600_0000 + 32'(i * 4);
            DMemWrDataQ103H  = 32'hB000_0000 + 32'(i);
            DMemByteEnQ103H  = 4'hF;
            exp_fab_q.push_back(mk(WR, DMemAddressQ103H, DMemWrDataQ103H, 4'hF));
        end
        cyc();
        DMemWrEnQ103H    = 1'b0;
        DMemRdEnQ103H    = 1'b1;
        DMemAddressQ103H = 32'h0300_0004;
        #1;
        check("ld_stall_first", C2F_StallQ103H, 1'b1);
        exp_fab_q.push_back(mk(RD, 32'h0300_0004, 32'h0000_0000, 4'hF));
        cyc();
        InFabricValidQ505H = 1'b1;
        InFabricQ505H      = mk_rsp(32'h0BAD_0BAD);
        #1;
        check("ld_stall_drain", C2F_StallQ103H, 1'b1);
        cyc();
        InFabricValidQ505H  = 1'b0;
        OutFabricReadyQ503H = 1'b1;
        wait_fab_drained("ld_order", 20);
        InFabricValidQ505H = 1'b1;
        InFabricQ505H      = mk_rsp(32'hCAFE_F00D);
        exp_rsp_q.push_back(32'hCAFE_F00D);
        cyc();
        idle_in();
        #1;
        check("ld_rsp_valid", C2F_RdRspValidQ104H, 1'b1);
        check("ld_rsp_stall", C2F_StallQ103H, 1'b0);
        cyc();
        check("ld_rsp_one_cycle", C2F_RdRspValidQ104H, 1'b0);
        check("ld_idle_stall", C2F_StallQ103H, 1'b0);

        // Load with no response.
        DMemRdEnQ103H    = 1'b1;
        DMemAddressQ103H = 32'h0400_0008;
        exp_fab_q.push_back(mk(RD, 32'h0400_0008, 32'h0000_0000, 4'hF));
        wait_fab_drained("to_rd", 10);
`ifdef BIG_CORE_C2F_TIMEOUT_EN
        exp_rsp_q.push_back(C2F_TIMEOUT_DATA);
        n = 1;
        while (!C2F_RdRspValidQ104H && n < 40) begin
            cyc();
            n++;
        end
        check("to_latency", n, 17);
        check("to_err_set", C2F_TimeoutErr, 1'b1);
        DMemRdEnQ103H = 1'b0;
        cyc();
        check("to_err_sticky", C2F_TimeoutErr, 1'b1);
        DMemRdEnQ103H    = 1'b1;
        DMemAddressQ103H = 32'h0400_000C;
        exp_fab_q.push_back(mk(RD, 32'h0400_000C, 32'h0000_0000, 4'hF));
        wait_fab_drained("to_rd2", 10);
        cyc();
        check("to_wait_stall", C2F_StallQ103H, 1'b1);
`else
        for (int i = 0; i < 40; i++) cyc();
        check("nto_wait_stall", C2F_StallQ103H, 1'b1);
        check("nto_no_rsp", C2F_RdRspValidQ104H, 1'b0);
        check("nto_err_zero", C2F_TimeoutErr, 1'b0);
`endif

        // Reset while waiting for the response; a late response is dropped.
        Rst = 1'b1;
        idle_in();
        #1;
        check("mid_rst_stall", C2F_StallQ103H, 1'b0);
        check("mid_rst_fab_valid", OutFabricValidQ503H, 1'b0);
        check("mid_rst_rsp_valid", C2F_RdRspValidQ104H, 1'b0);
        check("mid_rst_err", C2F_TimeoutErr, 1'b0);
        cyc();
        cyc();
        Rst                = 1'b0;
        InFabricValidQ505H = 1'b1;
        InFabricQ505H      = mk_rsp(32'h5555_AAAA);
        cyc();
        idle_in();
        #1;
        check("late_rsp_dropped", C2F_RdRspValidQ104H, 1'b0);
        check("post_rst_stall", C2F_StallQ103H, 1'b0);
        check("post_rst_fab_valid", OutFabricValidQ503H, 1'b0);

        // Bridge back in IDLE: a remote store goes straight out.
        DMemWrEnQ103H    = 1'b1;
        DMemAddressQ103H = 32'h0700_0000;
        DMemWrDataQ103H  = 32'h0BEE_F000;
        DMemByteEnQ103H  = 4'hF;
        exp_fab_q.push_back(mk(WR, 32'h0700_0000, 32'h0BEE_F000, 4'hF));
        cyc();
        idle_in();
        check("post_rst_wr_valid", OutFabricValidQ503H, 1'b1);
        wait_fab_drained("post_rst_drain", 5);
        cyc();
        check("final_rsp_queue", exp_rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
